// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// Optional even-parity support is selected with macro UART_RX_PARITY_EN.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int DATA_BITS_DEF    = 8;

`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_EN  = 1'b1;
    localparam int FRAME_BITS = DATA_BITS_DEF + 3;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    localparam bit PARITY_EN  = 1'b0;
    localparam int FRAME_BITS = DATA_BITS_DEF + 2;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; reset value is a parameter.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver with single-entry holding register, frame-error and overrun pulses.
// Macro UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev_q;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, ferr_q, ovr_q;
    logic                 tick, fall, byte_done, byte_bad;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .d_i    (rx),
        .q_o    (rx_s)
    );

    assign tick = (cnt_q == '0);
    assign fall = rx_prev_q && !rx_s;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (fall) state_d = START;
            START: if (tick) state_d = rx_s ? IDLE : DATA;
            DATA: begin
                if (tick && bit_q == LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) state_d = STOP;
`endif
            STOP:  if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter only decrements toward zero; every sample point reloads it.
    always_comb begin
        cnt_d     = tick ? cnt_q : cnt_q - 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        byte_done = 1'b0;
        byte_bad  = 1'b0;
        case (state_q)
            IDLE: if (fall) cnt_d = HALF;
            START: begin
                if (tick && !rx_s) begin
                    cnt_d     = FULL;
                    bit_d     = '0;
                    par_err_d = 1'b0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    cnt_d   = FULL;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_err_d = (^shift_q) ^ rx_s;
                    cnt_d     = FULL;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    byte_done = rx_s && !par_err_q;
                    byte_bad  = !byte_done;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            ferr_q    <= byte_bad;
            ovr_q     <= byte_done && valid_q && !rx_ready;
            if (byte_done && (!valid_q || rx_ready)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx; delivered bytes are checked against a queue of expected bytes.
module tb_uart_rx;

    localparam int CPB = 434;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int n_ferr = 0, n_ovr = 0, n_vcyc = 0;
    logic [7:0] exp_q[$];

    always #5 clk_in = ~clk_in;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (frame_err) n_ferr++;
        if (overrun)   n_ovr++;
        if (rx_valid)  n_vcyc++;
        if (rx_valid && rx_ready) begin
            check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            cycles(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_b;
        cycles(CPB);
`endif
        rx = stop_b;
        cycles(CPB);
        rx = 1'b1;
    endtask

    function automatic logic epar(input logic [7:0] d);
        return ^d;
    endfunction

    int f0, v0;

    initial begin
        cycles(5);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        cycles(20);

        // single byte, consumer always ready
        rx_ready = 1'b1;
        v0 = n_vcyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, epar(8'hA5));
        cycles(20);
        check("a5_delivered", 32'(exp_q.size()), 32'd0);
        check("a5_valid_cycles", 32'(n_vcyc - v0), 32'd1);
        check("a5_ferr", 32'(n_ferr), 32'd0);
        check("a5_ovr", 32'(n_ovr), 32'd0);

        // back-to-back with consumer stalled
        rx_ready = 1'b0;
        send_frame(8'h3C, 1'b1, epar(8'h3C));
        send_frame(8'hC3, 1'b1, epar(8'hC3));
        cycles(20);
        check("hold_valid", 32'(rx_valid), 32'd1);
        check("hold_data", 32'(rx_data), 32'h3C);
        check("ovr_count", 32'(n_ovr), 32'd1);
        check("ovr_no_ferr", 32'(n_ferr), 32'd0);
        exp_q.push_back(8'h3C);
        rx_ready = 1'b1;
        cycles(5);
        check("hold_drained", 32'(exp_q.size()), 32'd0);
        check("hold_valid_clear", 32'(rx_valid), 32'd0);

        // stop bit forced low
        v0 = n_vcyc;
        send_frame(8'h55, 1'b0, epar(8'h55));
        cycles(20);
        check("stop_low_ferr", 32'(n_ferr), 32'd1);
        check("stop_low_novalid", 32'(n_vcyc - v0), 32'd0);

        // short low glitch on idle line
        v0 = n_vcyc;
        rx = 1'b0;
        cycles(100);
        rx = 1'b1;
        cycles(2 * CPB);
        check("glitch_ferr", 32'(n_ferr), 32'd1);
        check("glitch_novalid", 32'(n_vcyc - v0), 32'd0);
        check("glitch_ovr", 32'(n_ovr), 32'd1);

        // reset in the middle of data bit 4 of 0xFF
        rx = 1'b0;
        cycles(CPB);
        rx = 1'b1;
        cycles(4 * CPB + CPB / 2);
        rst_n = 1'b0;
        cycles(10);
        rst_n = 1'b1;
        cycles(5 * CPB);
        check("abort_novalid", 32'(rx_valid), 32'd0);
        check("abort_ferr", 32'(n_ferr), 32'd1);
        exp_q.push_back(8'h12);
        v0 = n_vcyc;
        send_frame(8'h12, 1'b1, epar(8'h12));
        cycles(20);
        check("after_rst_delivered", 32'(exp_q.size()), 32'd0);
        check("after_rst_valid_cycles", 32'(n_vcyc - v0), 32'd1);

`ifdef UART_RX_PARITY_EN
        f0 = n_ferr;
        v0 = n_vcyc;
        send_frame(8'h07, 1'b1, 1'b0);
        cycles(20);
        check("par_bad_ferr", 32'(n_ferr - f0), 32'd1);
        check("par_bad_novalid", 32'(n_vcyc - v0), 32'd0);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        cycles(20);
        check("par_good_delivered", 32'(exp_q.size()), 32'd0);
        check("par_good_ferr", 32'(n_ferr - f0), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, gives clk_in cycles per serial bit (50 MHz / 115200).
REQ-002 Parameter DATA_BITS, default 8, gives data bits per frame; it SHALL be legal in the range 5..8.
REQ-003 Port clk_in, input, 1 bit, is the single clock; all logic is rising-edge.
REQ-004 Port rst_n, input, 1 bit, is the asynchronous active-low reset.
REQ-005 Port rx, input, 1 bit, is the serial line; it idles high and is asynchronous to clk_in.
REQ-006 Port rx_data, output, DATA_BITS bits, carries the received byte, LSB first on the wire.
REQ-007 Port rx_valid, output, 1 bit, high while rx_data holds an unconsumed byte.
REQ-008 Port rx_ready, input, 1 bit, is the consumer acceptance.
REQ-009 Port frame_err, output, 1 bit, is a one-cycle pulse when the stop bit is sampled low.
REQ-010 Port overrun, output, 1 bit, is a one-cycle pulse when a byte is dropped because the holding register is full.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer, reset to 1, before any use; this adds 2 cycles of latency.
REQ-012 The FSM SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE -> START on a synchronized falling edge (high then low); the bit counter loads CLKS_PER_BIT/2-1.
REQ-014 START: at counter zero, if the line is low go to DATA with the counter at CLKS_PER_BIT-1; if high (glitch) return to IDLE with no output.
REQ-015 DATA: sample once per CLKS_PER_BIT at mid-bit and shift right into the shift register; after DATA_BITS samples go to PARITY if enabled, else STOP.
REQ-016 STOP: sample at mid-bit, then return to IDLE in the same cycle, so a back-to-back start bit is detectable within half a bit.
REQ-017 In STOP, a high sample with no parity error SHALL complete the byte; a low sample SHALL pulse frame_err and discard the byte.
REQ-018 On completion with rx_valid low, the module SHALL load rx_data and set rx_valid on the next cycle.
REQ-019 On completion with rx_valid high and rx_ready low, rx_data SHALL be held, the new byte dropped, and overrun pulsed.
REQ-020 On completion in the same cycle as rx_valid&&rx_ready, the handshake SHALL be honoured and the new byte loaded, rx_valid staying high, with no overrun.
REQ-021 The handshake occurs when rx_valid&&rx_ready; rx_valid clears next cycle unless REQ-020 applies.
REQ-022 rx_data SHALL be stable while rx_valid is high.
REQ-023 The bit counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and SHALL never wrap below zero; it reloads on each sample.

Reset
REQ-024 Reset SHALL set state IDLE, counters 0, shift register 0, rx_data 0, rx_valid 0, frame_err 0, overrun 0, and synchronizer flops 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame without output; after release, reception SHALL resume only at the next falling edge.

Configuration
REQ-026 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL sample one even-parity bit after the data bits.
REQ-027 With UART_RX_PARITY_EN defined, a parity mismatch SHALL discard the byte and pulse frame_err at the STOP sample.
REQ-028 Without UART_RX_PARITY_EN, the PARITY state and its logic SHALL be absent and the frame SHALL be start+data+stop.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum type, the default CLKS_PER_BIT constant and the parity-enable-dependent frame length constant.
REQ-030 The synchronizer SHALL be sub-module uart_sync2 (2-flop, reset value parameterized); everything else SHALL be in uart_rx.

Verification
REQ-031 Send 0xA5 at 434 cycles/bit with rx_ready=1 -> rx_valid pulses one cycle with rx_data=0xA5, no errors.
REQ-032 Send 0x3C then 0xC3 back-to-back with rx_ready=0 -> first byte held as 0x3C, overrun pulses once at the second byte's stop sample.
REQ-033 Send 0x55 with the stop bit forced low -> frame_err pulses, rx_valid stays 0.
REQ-034 Drive a 100-cycle low glitch on an idle line -> FSM returns to IDLE, no rx_valid, no frame_err.
REQ-035 Assert rst_n low during data bit 4 of 0xFF, release, then send 0x12 -> only 0x12 is delivered.
REQ-036 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> frame_err pulses; with parity bit 1 -> 0x07 is delivered.
